// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the IF and MEM pipeline stages,
// one access per requester per advance window. Optional counters: MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fetch_count,
    output logic [31:0]       data_count,
`endif
    output logic              freeze
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_e;
    typedef enum logic {GNT_FETCH, GNT_DATA} grant_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              if_served_q, if_served_d;
    logic              mem_served_q, mem_served_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;
    logic              acc_we_q, acc_we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_req;
    logic if_pending;
    logic mem_pending;
    logic last_beat;

    assign mem_req     = mem_r_en | mem_w_en;
    assign if_pending  = if_req & ~if_served_q;
    assign mem_pending = mem_req & ~mem_served_q;
    assign last_beat   = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT);
    assign freeze      = if_pending | mem_pending;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output is given a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (mem_pending || if_pending) state_d = ST_ACCESS;
            ST_ACCESS: if (last_beat) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_we = 1'b0;
        sram_oe = 1'b0;
        if (state_q == ST_ACCESS) begin
            sram_we = acc_we_q;
            sram_oe = ~acc_we_q;
        end
    end

    // Access registers double as the SRAM address/data drivers, so they hold
    // their last value between accesses.
    assign sram_addr  = acc_addr_q;
    assign sram_wdata = acc_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

    always_comb begin
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        acc_addr_d   = acc_addr_q;
        acc_wdata_d  = acc_wdata_q;
        acc_we_d     = acc_we_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_served_d  = if_served_q;
        mem_served_d = mem_served_q;

        if (!freeze) begin
            if_served_d  = 1'b0;
            mem_served_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (mem_pending) begin
                grant_d     = GNT_DATA;
                acc_addr_d  = mem_addr;
                acc_wdata_d = mem_wdata;
                acc_we_d    = mem_w_en;
                cnt_d       = 4'd0;
            end else if (if_pending) begin
                grant_d     = GNT_FETCH;
                acc_addr_d  = if_addr;
                acc_wdata_d = mem_wdata;
                acc_we_d    = 1'b0;
                cnt_d       = 4'd0;
            end
        end else begin
            cnt_d = cnt_q + 4'd1;
            // Completion wins over the window-end clear when a requester
            // dropped its request mid-access.
            if (last_beat) begin
                cnt_d = 4'd0;
                if (grant_q == GNT_DATA) begin
                    mem_served_d = 1'b1;
                    if (!acc_we_q) mem_rdata_d = sram_rdata;
                end else begin
                    if_served_d = 1'b1;
                    if_rdata_d  = sram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q      <= GNT_FETCH;
            cnt_q        <= 4'd0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            acc_we_q     <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_served_q  <= 1'b0;
            mem_served_q <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            acc_addr_q   <= acc_addr_d;
            acc_wdata_q  <= acc_wdata_d;
            acc_we_q     <= acc_we_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_served_q  <= if_served_d;
            mem_served_q <= mem_served_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] data_count_q, data_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fetch_count_d  = fetch_count_q;
        data_count_d   = data_count_q;
        if (freeze) stall_cycles_d = stall_cycles_q + 32'd1;
        if (last_beat) begin
            if (grant_q == GNT_DATA) data_count_d  = data_count_q + 32'd1;
            else                     fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            fetch_count_q  <= '0;
            data_count_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fetch_count_q  <= fetch_count_d;
            data_count_q   <= data_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fetch_count  = fetch_count_q;
    assign data_count   = data_count_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with WAIT_CYCLES=3 and a
// small behavioural SRAM answering reads combinationally.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_oe;
    logic [DATA_W-1:0] sram_rdata;
    logic              freeze;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       fetch_count;
    logic [31:0]       data_count;
`endif

    logic [DATA_W-1:0] mem [0:255];
    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] wdata_q[$];

    int checks   = 0;
    int failures = 0;
    int nf, no, nw;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_rdata (sram_rdata),
`ifdef MEM_ARB_STATS_EN
        .stall_cycles (stall_cycles),
        .fetch_count  (fetch_count),
        .data_count   (data_count),
`endif
        .freeze     (freeze)
    );

    always #5 clk = ~clk;

    assign sram_rdata = mem[sram_addr[7:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge right after driving requests; returns at the first
    // negedge where freeze is low, having tallied the frozen cycles.
    task automatic run_window(output int n_freeze, output int n_oe, output int n_we);
        n_freeze = 0;
        n_oe     = 0;
        n_we     = 0;
        addr_q.delete();
        wdata_q.delete();
        #1;
        while (freeze && n_freeze < 40) begin
            n_freeze++;
            if (sram_oe) n_oe++;
            if (sram_we) begin
                n_we++;
                wdata_q.push_back(sram_wdata);
            end
            if (sram_oe || sram_we) addr_q.push_back(sram_addr);
            @(negedge clk);
        end
    endtask

    task automatic check_addrs(input string tag, input logic [ADDR_W-1:0] a0,
                               input logic [ADDR_W-1:0] a1, input int n0, input int n1);
        check({tag, "_naddr"}, 64'(addr_q.size()), 64'(n0 + n1));
        for (int i = 0; i < addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(addr_q[i]), 64'((i < n0) ? a0 : a1));
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hE3A01005;
        mem[8'h14] = 32'hE2811001;
        mem[8'h18] = 32'hE0800001;
        mem[8'h1C] = 32'hE1A00000;
        mem[8'h20] = 32'hA5A5A5A5;
        mem[8'h40] = 32'h12345678;
        mem[8'h44] = 32'h0BADF00D;

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_freeze", 64'(freeze), 64'd0);
        check("rst_we", 64'(sram_we), 64'd0);
        check("rst_oe", 64'(sram_oe), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_wdata", 64'(sram_wdata), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_freeze", 64'(freeze), 64'd0);
        check("idle_oe", 64'(sram_oe), 64'd0);

        // Fetch only
        if_req  = 1'b1;
        if_addr = 32'h10;
        run_window(nf, no, nw);
        check("f_freeze_cycles", 64'(nf), 64'd4);
        check("f_oe_cycles", 64'(no), 64'd3);
        check("f_we_cycles", 64'(nw), 64'd0);
        check_addrs("f", 32'h10, 32'h10, 3, 0);
        check("f_if_rdata", 64'(if_rdata), 64'hE3A01005);
        check("f_oe_after", 64'(sram_oe), 64'd0);
        check("f_addr_hold", 64'(sram_addr), 64'h10);
        idle_inputs();
        @(negedge clk);
        check("f_freeze_idle", 64'(freeze), 64'd0);

        // Fetch plus load in the same window: DATA first
        if_req   = 1'b1;
        if_addr  = 32'h18;
        mem_r_en = 1'b1;
        mem_addr = 32'h40;
        run_window(nf, no, nw);
        check("fl_freeze_cycles", 64'(nf), 64'd8);
        check("fl_oe_cycles", 64'(no), 64'd6);
        check_addrs("fl", 32'h40, 32'h18, 3, 3);
        check("fl_mem_rdata", 64'(mem_rdata), 64'h12345678);
        check("fl_if_rdata", 64'(if_rdata), 64'hE0800001);
        idle_inputs();
        @(negedge clk);

        // Store
        mem_w_en  = 1'b1;
        mem_addr  = 32'h80;
        mem_wdata = 32'hDEADBEEF;
        run_window(nf, no, nw);
        check("st_freeze_cycles", 64'(nf), 64'd4);
        check("st_we_cycles", 64'(nw), 64'd3);
        check("st_oe_cycles", 64'(no), 64'd0);
        check_addrs("st", 32'h80, 32'h80, 3, 0);
        for (int i = 0; i < wdata_q.size(); i++)
            check($sformatf("st_wdata%0d", i), 64'(wdata_q[i]), 64'hDEADBEEF);
        check("st_mem_rdata_held", 64'(mem_rdata), 64'h12345678);
        check("st_if_rdata_held", 64'(if_rdata), 64'hE0800001);
        check("st_we_after", 64'(sram_we), 64'd0);
        idle_inputs();
        @(negedge clk);

        // Back-to-back windows with if_req held
        if_req  = 1'b1;
        if_addr = 32'h10;
        run_window(nf, no, nw);
        check("bb1_freeze_cycles", 64'(nf), 64'd4);
        check("bb1_if_rdata", 64'(if_rdata), 64'hE3A01005);
        if_addr = 32'h14;
        @(negedge clk);
        check("bb_new_window_freeze", 64'(freeze), 64'd1);
        run_window(nf, no, nw);
        check("bb2_freeze_cycles", 64'(nf), 64'd4);
        check_addrs("bb2", 32'h14, 32'h14, 3, 0);
        check("bb2_if_rdata", 64'(if_rdata), 64'hE2811001);
        idle_inputs();
        @(negedge clk);

        // Reset in the middle of an access
        if_req  = 1'b1;
        if_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        check("ra_oe_before", 64'(sram_oe), 64'd1);
        rst = 1'b0;
        #1;
        check("ra_oe_async", 64'(sram_oe), 64'd0);
        check("ra_we_async", 64'(sram_we), 64'd0);
        check("ra_freeze", 64'(freeze), 64'd1);
        check("ra_if_rdata", 64'(if_rdata), 64'd0);
        check("ra_mem_rdata", 64'(mem_rdata), 64'd0);
        @(negedge clk);
        check("ra_oe_held", 64'(sram_oe), 64'd0);
        check("ra_if_rdata_held", 64'(if_rdata), 64'd0);
        rst = 1'b1;
        run_window(nf, no, nw);
        check("ra_freeze_cycles", 64'(nf), 64'd4);
        check_addrs("ra", 32'h20, 32'h20, 3, 0);
        check("ra_if_rdata_new", 64'(if_rdata), 64'hA5A5A5A5);
        idle_inputs();
        @(negedge clk);

        // Clean reset, then fetch plus load again (counter scenario)
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`ifdef MEM_ARB_STATS_EN
        check("cnt_rst_stall", 64'(stall_cycles), 64'd0);
        check("cnt_rst_fetch", 64'(fetch_count), 64'd0);
        check("cnt_rst_data", 64'(data_count), 64'd0);
`endif
        @(negedge clk);
        if_req   = 1'b1;
        if_addr  = 32'h1C;
        mem_r_en = 1'b1;
        mem_addr = 32'h44;
        run_window(nf, no, nw);
        check("fl2_freeze_cycles", 64'(nf), 64'd8);
        check_addrs("fl2", 32'h44, 32'h1C, 3, 3);
        check("fl2_mem_rdata", 64'(mem_rdata), 64'h0BADF00D);
        check("fl2_if_rdata", 64'(if_rdata), 64'hE1A00000);
`ifdef MEM_ARB_STATS_EN
        check("cnt_stall", 64'(stall_cycles), 64'd8);
        check("cnt_fetch", 64'(fetch_count), 64'd1);
        check("cnt_data", 64'(data_count), 64'd1);
`endif
        idle_inputs();
        @(negedge clk);
        check("end_freeze", 64'(freeze), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access with a fixed wait-state count.
- Serves each pending requester exactly once per pipeline advance window.
- Produces the pipeline freeze that holds all stages until every pending access of the current window has completed.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 3, cycles an access occupies the memory; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- if_req  in  1  fetch request; held by IF while frozen
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request; never asserted together with mem_r_en
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, registered
- sram_addr  out  ADDR_W  memory address
- sram_wdata  out  DATA_W  memory write data
- sram_we  out  1  memory write enable
- sram_oe  out  1  memory read enable
- sram_rdata  in  DATA_W  memory read data, valid on the last access cycle
- freeze  out  1  stall the whole pipeline

Behaviour:
- Definitions:
  - mem_req = mem_r_en | mem_w_en
  - Served flags: if_served and mem_served are registered.
  - freeze (combinational) = (if_req & ~if_served) | (mem_req & ~mem_served)
- Window end: at any clock edge where freeze == 0, clear both served flags.
- FSM states:
  - IDLE:
    - If mem_req & ~mem_served: grant DATA. MEM-stage priority, since it is the older instruction.
    - Else if if_req & ~if_served: grant FETCH.
    - Else stay in IDLE.
    - On a grant edge: latch address, wdata and we (we = mem_w_en for DATA, 0 for FETCH) into access registers; cnt <= 0; go to ACCESS.
  - ACCESS:
    - sram_addr and sram_wdata come from the access registers.
    - sram_we = latched we; sram_oe = ~latched we.
    - cnt increments each cycle.
    - On the edge where cnt == WAIT_CYCLES-1:
      - DATA read: capture sram_rdata into mem_rdata.
      - FETCH: capture sram_rdata into if_rdata.
      - DATA write: no capture.
      - Set the granted served flag; go to IDLE.
- Requester inputs are ignored during ACCESS. The latched values are used.
- Latency per access:
  - WAIT_CYCLES cycles in ACCESS, plus 1 IDLE arbitration cycle.
  - One requester: freeze is high for WAIT_CYCLES+1 cycles.
  - Both requesters: freeze is high for 2*(WAIT_CYCLES+1) cycles, DATA first.
- Outside ACCESS: sram_we = 0, sram_oe = 0, sram_addr and sram_wdata hold their last values.
- if_rdata and mem_rdata hold their values until the next capture.
- Reset values (asynchronous, while rst = 0):
  - State IDLE, cnt 0, served flags 0.
  - sram_we 0, sram_oe 0, sram_addr 0, sram_wdata 0.
  - if_rdata 0, mem_rdata 0.
  - freeze follows the combinational equation using the cleared flags.
- Reset mid-access: the access is aborted immediately, with no capture and no served flag set. After release the request is re-arbitrated from IDLE.
- No requests: FSM stays in IDLE, freeze 0.
- Requester drops its request during its own ACCESS: the access still completes and sets its served flag. The flag is cleared at the next freeze == 0 edge.
- WAIT_CYCLES == 1: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, the block adds three outputs, each 32 bits:
  - stall_cycles: increments every cycle with freeze == 1.
  - fetch_count: increments on each completed FETCH.
  - data_count: increments on each completed DATA access.
- All three counters reset to 0 and wrap modulo 2^32.
- When not defined, these ports and registers are absent. Behaviour is otherwise identical.

Test Plan:
All scenarios use WAIT_CYCLES=3.
- Fetch only: if_req=1, if_addr=0x10, memory[0x10]=0xE3A01005 -> freeze high for 4 cycles; sram_oe high for 3 cycles with sram_addr=0x10; if_rdata=0xE3A01005; then freeze=0.
- Fetch plus load in the same window: if_req=1 and mem_r_en=1, mem_addr=0x40 -> DATA is served first (sram_addr=0x40), then FETCH; freeze high for exactly 8 cycles; mem_rdata and if_rdata are both correct.
- Store: mem_w_en=1, mem_addr=0x80, mem_wdata=0xDEADBEEF -> sram_we high for 3 cycles with those values; sram_oe=0; mem_rdata unchanged; freeze high for 4 cycles.
- Back-to-back windows: fetch completes, freeze drops for one edge, next if_addr=0x14 -> served flags clear and a new 4-cycle fetch occurs from 0x14, with no stale data.
- Reset mid-access: rst=0 during ACCESS cycle 2 -> sram_we and sram_oe drop to 0 asynchronously; no capture. After rst=1 with if_req still high -> full 4-cycle fetch restarts.
- MEM_ARB_STATS_EN: the fetch-plus-load scenario -> stall_cycles=8, fetch_count=1, data_count=1.
